// File: rtl/wb_arb_if.sv
// Write-back port bundle: pipeline write, MDU valid/ready result and register-file write.
interface wb_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              p_wen_i;
    logic [ADDR_W-1:0] p_rd_addr_i;
    logic [DATA_W-1:0] p_rd_data_i;
    logic              m_valid_i;
    logic [ADDR_W-1:0] m_rd_addr_i;
    logic [DATA_W-1:0] m_rd_data_i;
    logic              m_ready_o;
    logic              hold_o;
    logic              regs_wen_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_o;

    // Arbiter side
    modport slave (
        input  p_wen_i, p_rd_addr_i, p_rd_data_i,
        input  m_valid_i, m_rd_addr_i, m_rd_data_i,
        output m_ready_o, hold_o, regs_wen_o, rd_addr_o, rd_data_o
    );

    // Pipeline / MDU / register-file side
    modport master (
        output p_wen_i, p_rd_addr_i, p_rd_data_i,
        output m_valid_i, m_rd_addr_i, m_rd_data_i,
        input  m_ready_o, hold_o, regs_wen_o, rd_addr_o, rd_data_o
    );
endinterface

// File: rtl/wb_arb.sv
// Write-back port arbiter: pipeline always wins, a single MDU result waits in a
// skid buffer, forces a one-cycle bubble when starved, and is squashed on WAW.
module wb_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      rstn,   // asynchronous, active-high despite the name
    wb_arb_if.slave   bus
);
    localparam logic [3:0] STARVE = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t            state, state_nxt;
    logic              buf_valid, buf_valid_nxt;
    logic [ADDR_W-1:0] buf_addr, buf_addr_nxt;
    logic [DATA_W-1:0] buf_data, buf_data_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt, cnt_inc;
    logic              hold, hold_nxt;
    logic              accept, squash, drop, clear;

    assign bus.m_ready_o = ~buf_valid;
    assign bus.hold_o    = hold;

    // Buffer leaves at the next edge if it writes now, targets x0, or was overtaken.
    always_comb begin
        accept  = bus.m_valid_i & ~buf_valid;
        drop    = buf_valid & (buf_addr == '0);
        squash  = buf_valid & bus.p_wen_i & (bus.p_rd_addr_i == buf_addr) & (buf_addr != '0);
        clear   = buf_valid & (~bus.p_wen_i | drop | squash);
        cnt_inc = (wait_cnt == STARVE) ? wait_cnt : wait_cnt + 4'd1;
    end

    // Next-state: buffer capture/drain, starvation counting, bubble request
    always_comb begin
        state_nxt     = state;
        buf_valid_nxt = buf_valid;
        buf_addr_nxt  = buf_addr;
        buf_data_nxt  = buf_data;
        wait_cnt_nxt  = wait_cnt;
        hold_nxt      = hold;
        case (state)
            IDLE: begin
                hold_nxt     = 1'b0;
                wait_cnt_nxt = 4'd0;
                if (accept) begin
                    buf_valid_nxt = 1'b1;
                    buf_addr_nxt  = bus.m_rd_addr_i;
                    buf_data_nxt  = bus.m_rd_data_i;
                    state_nxt     = PEND;
                end
            end
            PEND: begin
                if (clear) begin
                    buf_valid_nxt = 1'b0;
                    wait_cnt_nxt  = 4'd0;
                    state_nxt     = IDLE;
                end else begin
                    wait_cnt_nxt = cnt_inc;
                    if (cnt_inc == STARVE) begin
                        hold_nxt  = 1'b1;
                        state_nxt = FORCE;
                    end
                end
            end
            FORCE: begin
                // The pipeline honours hold, so the buffer always leaves here;
                // staying put otherwise keeps the buffer from being lost.
                if (clear) begin
                    buf_valid_nxt = 1'b0;
                    wait_cnt_nxt  = 4'd0;
                    hold_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and buffer registers
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            wait_cnt  <= 4'd0;
            hold      <= 1'b0;
        end else begin
            state     <= state_nxt;
            buf_valid <= buf_valid_nxt;
            buf_addr  <= buf_addr_nxt;
            buf_data  <= buf_data_nxt;
            wait_cnt  <= wait_cnt_nxt;
            hold      <= hold_nxt;
        end
    end

    // Write-port mux: pipeline first, then a non-x0 buffered result, else idle
    always_comb begin
        bus.regs_wen_o = 1'b0;
        bus.rd_addr_o  = '0;
        bus.rd_data_o  = '0;
        if (!rstn) begin
            if (bus.p_wen_i) begin
                bus.regs_wen_o = 1'b1;
                bus.rd_addr_o  = bus.p_rd_addr_i;
                bus.rd_data_o  = bus.p_rd_data_i;
            end else if (buf_valid && buf_addr != '0) begin
                bus.regs_wen_o = 1'b1;
                bus.rd_addr_o  = buf_addr;
                bus.rd_data_o  = buf_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: directed test-plan scenarios, then random
// pipeline/MDU traffic against a transaction-level model of the pending result.
module tb_wb_arb;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_bad = 0;

    wb_arb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    wb_arb #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(S)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    // Model: at most one outstanding MDU result and how long it has been blocked
    logic        mb_v, mb_hold;
    logic [4:0]  mb_a;
    logic [31:0] mb_d;
    int          mb_age;

    // Last observed outputs, for directed constant checks
    logic        obs_wen, obs_ready, obs_hold;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mb_v = 1'b0; mb_hold = 1'b0; mb_a = '0; mb_d = '0; mb_age = 0;
    endfunction

    // One clock: drive after the edge, check at the falling edge, advance model at the edge
    task automatic cycle(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         output logic acc);
        logic        e_wen;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        bus.p_wen_i = pw; bus.p_rd_addr_i = pa; bus.p_rd_data_i = pd;
        bus.m_valid_i = mv; bus.m_rd_addr_i = ma; bus.m_rd_data_i = md;
        @(negedge clk);
        e_wen = 1'b0; e_a = '0; e_d = '0;
        if (pw) begin
            e_wen = 1'b1; e_a = pa; e_d = pd;
        end else if (mb_v && mb_a != 0) begin
            e_wen = 1'b1; e_a = mb_a; e_d = mb_d;
        end
        obs_wen = bus.regs_wen_o; obs_addr = bus.rd_addr_o; obs_data = bus.rd_data_o;
        obs_ready = bus.m_ready_o; obs_hold = bus.hold_o;
        chk("ready", 64'(bus.m_ready_o), 64'(!mb_v));
        chk("hold", 64'(bus.hold_o), 64'(mb_hold));
        chk("wen", 64'(bus.regs_wen_o), 64'(e_wen));
        chk("addr", 64'(bus.rd_addr_o), 64'(e_a));
        chk("data", 64'(bus.rd_data_o), 64'(e_d));
        chk("pwen_under_hold", 64'(pw & bus.hold_o), 64'd0);
        acc = mv && !mb_v;
        @(posedge clk);
        if (mb_v) begin
            if (!pw || mb_a == 0 || pa == mb_a) begin
                mb_v = 1'b0; mb_age = 0; mb_hold = 1'b0;
            end else begin
                if (mb_age < S) mb_age++;
                mb_hold = (mb_age == S);
            end
        end else if (mv) begin
            mb_v = 1'b1; mb_a = ma; mb_d = md; mb_age = 0;
        end
        #1;
    endtask

    logic        acc, tm_v;
    logic [4:0]  tm_a;
    logic [31:0] tm_d;
    logic        pw;

    initial begin
        model_reset();
        rstn = 1'b1;
        bus.p_wen_i = 0; bus.p_rd_addr_i = 0; bus.p_rd_data_i = 0;
        bus.m_valid_i = 0; bus.m_rd_addr_i = 0; bus.m_rd_data_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.m_ready_o), 64'd1);
        chk("rst_hold", 64'(bus.hold_o), 64'd0);
        chk("rst_wen", 64'(bus.regs_wen_o), 64'd0);
        @(negedge clk) rstn = 1'b0;
        @(posedge clk); #1;

        // Pipeline only
        cycle(1, 5, 32'h1234, 0, 0, 0, acc);
        chk("pipe_wen", 64'(obs_wen), 64'd1);
        chk("pipe_addr", 64'(obs_addr), 64'd5);
        chk("pipe_data", 64'(obs_data), 64'h1234);
        chk("pipe_ready", 64'(obs_ready), 64'd1);

        // MDU on idle port: written one cycle after acceptance
        cycle(0, 0, 0, 1, 7, 32'hDEADBEEF, acc);
        chk("mdu_acc_nowr", 64'(obs_wen), 64'd0);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("mdu_wen", 64'(obs_wen), 64'd1);
        chk("mdu_addr", 64'(obs_addr), 64'd7);
        chk("mdu_data", 64'(obs_data), 64'hDEADBEEF);
        chk("mdu_busy", 64'(obs_ready), 64'd0);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("mdu_ready_back", 64'(obs_ready), 64'd1);

        // Starvation: four blocked cycles, then a one-cycle bubble
        cycle(0, 0, 0, 1, 9, 32'h99, acc);
        for (int i = 0; i < S; i++) begin
            cycle(1, 1, 32'h100 + i, 0, 0, 0, acc);
            chk("starve_nohold", 64'(obs_hold), 64'd0);
        end
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("starve_hold", 64'(obs_hold), 64'd1);
        chk("starve_wr_addr", 64'(obs_addr), 64'd9);
        chk("starve_wr_data", 64'(obs_data), 64'h99);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("starve_hold_drop", 64'(obs_hold), 64'd0);

        // WAW squash
        cycle(0, 0, 0, 1, 3, 32'hAA, acc);
        cycle(1, 3, 32'hBB, 0, 0, 0, acc);
        chk("waw_data", 64'(obs_data), 64'hBB);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("waw_nowr", 64'(obs_wen), 64'd0);
        chk("waw_ready", 64'(obs_ready), 64'd1);

        // x0 result: accepted, then dropped silently
        cycle(0, 0, 0, 1, 0, 32'h55, acc);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("x0_nowr", 64'(obs_wen), 64'd0);
        chk("x0_busy", 64'(obs_ready), 64'd0);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("x0_ready", 64'(obs_ready), 64'd1);

        // Reset while pending with two blocked cycles
        cycle(0, 0, 0, 1, 9, 32'h77, acc);
        cycle(1, 1, 32'h1, 0, 0, 0, acc);
        cycle(1, 1, 32'h2, 0, 0, 0, acc);
        bus.p_wen_i = 0;
        #2 rstn = 1'b1;
        #1;
        chk("rmid_ready", 64'(bus.m_ready_o), 64'd1);
        chk("rmid_hold", 64'(bus.hold_o), 64'd0);
        chk("rmid_wen", 64'(bus.regs_wen_o), 64'd0);
        model_reset();
        @(negedge clk) rstn = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, acc);
            chk("rmid_nostale", 64'(obs_wen), 64'd0);
        end

        // Random traffic; the MDU keeps its result stable until accepted
        tm_v = 1'b0; tm_a = '0; tm_d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!tm_v && ($urandom % 3 == 0)) begin
                tm_v = 1'b1;
                tm_a = 5'($urandom % 8);
                tm_d = $urandom;
            end
            pw = mb_hold ? 1'b0 : ($urandom % 10 < 6);
            cycle(pw, 5'($urandom % 8), $urandom, tm_v, tm_a, tm_d, acc);
            if (acc) tm_v = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
